bp_update_ctrl: RTL and testbench

Sequencing controller for the gshare branch predictor's PHT and BHSR.
- After reset or on request, it walks all PHT entries to a fixed init value.
- It queues resolved-branch outcomes from EX and drains them one per cycle into the predictor's write port.
- It detects mispredictions and issues the PC redirect and flush to the fetch stage.
- It sits between the EX-stage branch unit, the predictor, and the PC mux.

---
 rtl/bp_update_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_bp_update_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bp_update_ctrl
// Purpose  : gshare PHT/BHSR sequencer: table init walk, queued update drain,
//            and mispredict redirect/flush generation.
// Revision : 1.0 - initial release
// ============================================================================
module bp_update_ctrl #(
    parameter int         IDX_W    = 5,
    parameter int         ENTRIES  = 32,
    parameter int         QDEPTH   = 4,
    parameter logic [1:0] INIT_VAL = 2'b11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_req,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic [IDX_W-1:0] res_pht_idx,
    input  logic             res_pred_taken,
    input  logic             res_real_taken,
    input  logic [31:0]      res_target,
    input  logic             port_hold,
    output logic             init_busy,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_waddr,
    output logic             pht_wmode,
    output logic             pht_wtaken,
    output logic             bhsr_clear,
    output logic             bhsr_shift,
    output logic             bhsr_bit,
    output logic             stall_req,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [15:0]      branch_cnt,
    output logic [15:0]      mispred_cnt,
    output logic [7:0]       drop_cnt
);

    localparam int c_PTR_W = $clog2(QDEPTH);
    localparam int c_CNT_W = $clog2(QDEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(QDEPTH);
    localparam logic [IDX_W-1:0]   c_LAST = IDX_W'(ENTRIES - 1);

    // The predictor applies INIT_VAL on mode-0 writes; reject inconsistent sizing.
    generate
        if ((ENTRIES != (1 << IDX_W)) || ((QDEPTH & (QDEPTH - 1)) != 0) ||
            (INIT_VAL > 2'b11)) begin : g_param_check
            $error("bp_update_ctrl: inconsistent parameters");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;

    logic [IDX_W-1:0]   r_q_idx [QDEPTH];
    logic               r_q_tk  [QDEPTH];
    logic [c_PTR_W-1:0] r_wp;
    logic [c_PTR_W-1:0] r_rp;
    logic [c_CNT_W-1:0] r_count;

    logic w_init_wr;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_full;
    logic w_discard;
    logic w_mispred;

    assign w_full    = (r_count == c_FULL);
    assign stall_req = w_full;
    assign w_mispred = res_valid && (res_pred_taken != res_real_taken);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_init_wr   = 1'b0;
        w_pop       = 1'b0;
        w_discard   = 1'b0;
        if (init_req) begin
            w_state_nxt = S_INIT;
            w_idx_nxt   = '0;
            w_discard   = 1'b1;
        end else begin
            case (r_state)
                S_INIT: begin
                    w_init_wr = 1'b1;
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (r_idx == c_LAST) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    w_pop = (r_count != '0) && !port_hold;
                end
                default: w_state_nxt = S_INIT;
            endcase
        end
        // A pop in the same cycle frees the slot a full-queue push needs.
        w_push = res_valid && !init_req && (!w_full || w_pop);
        w_drop = res_valid && !init_req && w_full && !w_pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (w_discard) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + c_PTR_W'(1);
            if (w_pop)  r_rp <= r_rp + c_PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_idx[r_wp] <= res_pht_idx;
            r_q_tk[r_wp]  <= res_real_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_busy      <= 1'b1;
            pht_we         <= 1'b0;
            pht_waddr      <= '0;
            pht_wmode      <= 1'b0;
            pht_wtaken     <= 1'b0;
            bhsr_clear     <= 1'b0;
            bhsr_shift     <= 1'b0;
            bhsr_bit       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
            drop_cnt       <= '0;
        end else begin
            init_busy  <= w_init_wr || init_req;
            pht_we     <= w_init_wr || w_pop;
            pht_waddr  <= w_init_wr ? r_idx : (w_pop ? r_q_idx[r_rp] : '0);
            pht_wmode  <= w_pop;
            pht_wtaken <= w_pop && r_q_tk[r_rp];
            bhsr_clear <= w_init_wr && (r_idx == '0);
            bhsr_shift <= w_pop;
            bhsr_bit   <= w_pop && r_q_tk[r_rp];

            redirect_valid <= w_mispred;
            flush          <= w_mispred;
            if (w_mispred) begin
                redirect_pc <= res_real_taken ? res_target : (res_pc + 32'd4);
            end

            if (res_valid && (branch_cnt != 16'hFFFF))  branch_cnt  <= branch_cnt + 16'd1;
            if (w_mispred && (mispred_cnt != 16'hFFFF)) mispred_cnt <= mispred_cnt + 16'd1;
            if (w_drop && (drop_cnt != 8'hFF))          drop_cnt    <= drop_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_update_ctrl
// Purpose  : Randomised bench for bp_update_ctrl against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_update_ctrl;

    localparam int IDX_W   = 5;
    localparam int ENTRIES = 32;
    localparam int QDEPTH  = 4;

    logic             clk;
    logic             reset;
    logic             init_req;
    logic             res_valid;
    logic [31:0]      res_pc;
    logic [IDX_W-1:0] res_pht_idx;
    logic             res_pred_taken;
    logic             res_real_taken;
    logic [31:0]      res_target;
    logic             port_hold;
    logic             init_busy;
    logic             pht_we;
    logic [IDX_W-1:0] pht_waddr;
    logic             pht_wmode;
    logic             pht_wtaken;
    logic             bhsr_clear;
    logic             bhsr_shift;
    logic             bhsr_bit;
    logic             stall_req;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic [15:0]      branch_cnt;
    logic [15:0]      mispred_cnt;
    logic [7:0]       drop_cnt;

    bp_update_ctrl #(
        .IDX_W    (IDX_W),
        .ENTRIES  (ENTRIES),
        .QDEPTH   (QDEPTH),
        .INIT_VAL (2'b11)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .init_req       (init_req),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_pht_idx    (res_pht_idx),
        .res_pred_taken (res_pred_taken),
        .res_real_taken (res_real_taken),
        .res_target     (res_target),
        .port_hold      (port_hold),
        .init_busy      (init_busy),
        .pht_we         (pht_we),
        .pht_waddr      (pht_waddr),
        .pht_wmode      (pht_wmode),
        .pht_wtaken     (pht_wtaken),
        .bhsr_clear     (bhsr_clear),
        .bhsr_shift     (bhsr_shift),
        .bhsr_bit       (bhsr_bit),
        .stall_req      (stall_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference state: pending updates as {idx,taken} codes in arrival order.
    int          q[$];
    int          m_in_init, m_pos;
    int          m_branch, m_mis, m_drop;
    logic [31:0] m_rpc;
    int          e_busy, e_we, e_waddr, e_wmode, e_wtaken;
    int          e_clear, e_shift, e_bit, e_redir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_in_init = 1; m_pos = 0;
        m_branch = 0; m_mis = 0; m_drop = 0; m_rpc = '0;
        e_busy = 1; e_we = 0; e_waddr = 0; e_wmode = 0; e_wtaken = 0;
        e_clear = 0; e_shift = 0; e_bit = 0; e_redir = 0;
    endtask

    task automatic model_edge();
        bit full, popped, mis;
        int h;
        if (reset) begin
            model_reset();
            return;
        end
        mis = res_valid && (res_pred_taken != res_real_taken);
        e_busy = 0; e_we = 0; e_waddr = 0; e_wmode = 0; e_wtaken = 0;
        e_clear = 0; e_shift = 0; e_bit = 0; e_redir = mis;
        if (res_valid) m_branch = (m_branch < 65535) ? m_branch + 1 : 65535;
        if (mis) begin
            m_mis = (m_mis < 65535) ? m_mis + 1 : 65535;
            m_rpc = res_real_taken ? res_target : res_pc + 32'd4;
        end
        full   = (q.size() == QDEPTH);
        popped = 0;
        if (init_req) begin
            q.delete();
            m_in_init = 1; m_pos = 0; e_busy = 1;
        end else begin
            if (m_in_init != 0) begin
                e_busy = 1; e_we = 1; e_waddr = m_pos; e_clear = (m_pos == 0);
                m_pos++;
                if (m_pos == ENTRIES) m_in_init = 0;
            end else if (q.size() > 0 && !port_hold) begin
                h = q.pop_front();
                e_we = 1; e_wmode = 1; e_waddr = h / 2;
                e_wtaken = h % 2; e_shift = 1; e_bit = h % 2;
                popped = 1;
            end
            if (res_valid) begin
                if (full && !popped) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else q.push_back(int'(res_pht_idx) * 2 + int'(res_real_taken));
            end
        end
    endtask

    task automatic compare();
        chk("init_busy", init_busy, e_busy);
        chk("pht_we", pht_we, e_we);
        if (e_we != 0) begin
            chk("pht_waddr", pht_waddr, e_waddr);
            chk("pht_wmode", pht_wmode, e_wmode);
            chk("pht_wtaken", pht_wtaken, e_wtaken);
        end
        chk("bhsr_clear", bhsr_clear, e_clear);
        chk("bhsr_shift", bhsr_shift, e_shift);
        if (e_shift != 0) chk("bhsr_bit", bhsr_bit, e_bit);
        chk("stall_req", stall_req, q.size() == QDEPTH);
        chk("redirect_valid", redirect_valid, e_redir);
        chk("flush", flush, e_redir);
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("branch_cnt", branch_cnt, m_branch);
        chk("mispred_cnt", mispred_cnt, m_mis);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic idle();
        init_req = 0; res_valid = 0; res_pc = '0; res_pht_idx = '0;
        res_pred_taken = 0; res_real_taken = 0; res_target = '0;
    endtask

    task automatic branch(input logic [31:0] pc, input int idx, input logic pred,
                          input logic real_tk, input logic [31:0] tgt);
        res_valid = 1; res_pc = pc; res_pht_idx = IDX_W'(idx);
        res_pred_taken = pred; res_real_taken = real_tk; res_target = tgt;
    endtask

    task automatic rand_branch();
        branch($urandom, int'($urandom_range(0, ENTRIES - 1)), 1'($urandom),
               1'($urandom), $urandom);
    endtask

    initial begin
        idle();
        port_hold = 0;
        reset = 0;
        model_reset();
        #1 reset = 1;
        step(); step();
        reset = 0;

        // Init walk after reset, then settle into RUN.
        repeat (36) step();

        branch(32'h40, 5, 1, 1, 32'h80);
        step(); idle(); repeat (3) step();

        branch(32'h100, 7, 1, 0, 32'h300);
        step();
        branch(32'h120, 9, 0, 1, 32'h200);
        step(); idle(); repeat (3) step();

        // Backpressure: five arrivals into a four-deep queue.
        port_hold = 1;
        for (int i = 0; i < 5; i++) begin
            branch(32'h1000 + 4 * i, i + 10, 0, i[0], 32'h2000);
            step();
        end
        idle(); step();
        port_hold = 0;
        repeat (6) step();

        // Re-init while two updates are pending.
        port_hold = 1;
        branch(32'h500, 3, 1, 1, 0); step();
        branch(32'h504, 4, 1, 0, 0); step();
        idle(); port_hold = 0;
        init_req = 1; step(); init_req = 0;
        repeat (36) step();

        // Asynchronous reset in the middle of a drain.
        port_hold = 1;
        for (int i = 0; i < 4; i++) begin
            branch(32'h600 + 4 * i, 20 + i, 1, 1, 0);
            step();
        end
        idle(); port_hold = 0; step();
        #2 reset = 1;
        #1 model_reset(); compare();
        step(); step();
        reset = 0;
        repeat (36) step();

        // Drop counter saturation under sustained backpressure.
        port_hold = 1;
        for (int i = 0; i < 270; i++) begin
            rand_branch(); step();
        end
        idle(); port_hold = 0; repeat (6) step();

        // Randomised traffic with occasional holds, re-inits and collisions.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 6) rand_branch();
            else idle();
            init_req = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0) port_hold = ~port_hold;
            step();
        end
        idle(); port_hold = 0;
        repeat (40) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
